// File: rtl/pwm_capture.sv
// PWM capture: synchronizes an asynchronous PWM line and measures the period and high time
// of each cycle in clock ticks. Each completed period is emitted as one AXI-stream beat.
module pwm_capture #(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         pwm_in,
  input  logic                         enable,
  input  logic [COUNTER_WIDTH-1:0]     timeout_cycles,
  input  logic                         clear_status,
  output logic [2*COUNTER_WIDTH-1:0]   data_out_tdata,
  output logic                         data_out_tvalid,
  input  logic                         data_out_tready,
  output logic                         data_out_tdest,
  output logic                         stuck_high,
  output logic                         stuck_low,
  output logic                         overrun
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic                     s1, s2, s3;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic [COUNTER_WIDTH-1:0] high_time;
  state_t                   state;

  logic rise, fall, timeout_hit, load;
  logic set_stuck_high, set_stuck_low, set_overrun;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // A timeout only counts when no edge arrives in the same cycle.
  assign timeout_hit    = (timeout_cycles != '0) && (cnt == timeout_cycles) && !(rise || fall);
  assign load           = enable && (state == LOW) && rise;
  assign set_stuck_high = enable && (state == HIGH) && timeout_hit;
  assign set_stuck_low  = enable && (state == LOW) && timeout_hit;
  assign set_overrun    = load && data_out_tvalid && !data_out_tready;

  assign data_out_tdest = 1'b0;

  // Synchronizer and free-running cycle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      cnt <= '0;
    end else begin
      s1  <= pwm_in;
      s2  <= s1;
      s3  <= s2;
      cnt <= rise ? CNT_ONE : sat_inc(cnt);
    end
  end

  // Measurement FSM, output register and sticky status
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      high_time       <= '0;
      data_out_tdata  <= '0;
      data_out_tvalid <= 1'b0;
      stuck_high      <= 1'b0;
      stuck_low       <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && rise) state <= HIGH;
        end
        HIGH: begin
          if (!enable) begin
            state <= IDLE;
          end else if (fall) begin
            high_time <= cnt;
            state     <= LOW;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        LOW: begin
          if (!enable)          state <= IDLE;
          else if (rise)        state <= HIGH;
          else if (timeout_hit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A load in the handshake cycle keeps valid high with the new data.
      if (load) begin
        data_out_tdata  <= {high_time, cnt};
        data_out_tvalid <= 1'b1;
      end else if (data_out_tvalid && data_out_tready) begin
        data_out_tvalid <= 1'b0;
      end

      stuck_high <= (stuck_high && !clear_status) || set_stuck_high;
      stuck_low  <= (stuck_low  && !clear_status) || set_stuck_low;
      overrun    <= (overrun    && !clear_status) || set_overrun;
    end
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Single-channel PWM measurement block: samples an asynchronous PWM line, measures the period and high time of each cycle in clock ticks, and emits one result beat per completed period on an AXI stream. It is the receive side of the PwmGenerator. It sits on generator outputs, or on externally sourced gate signals, to provide closed-loop verification and on-line duty feedback to the control cores.

## Interface
Parameters:
- COUNTER_WIDTH, 16, width of the cycle counter and of each measured field.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- enable  in  1  measurement enable, level-sensitive.
- timeout_cycles  in  COUNTER_WIDTH  number of cycles without an edge before the line is declared stuck. 0 disables the timeout.
- clear_status  in  1  single-cycle pulse that clears the sticky flags.
- data_out  axi_stream master.
  - data[2*COUNTER_WIDTH-1:0] = {high_time, period}.
  - The valid and ready signals are used.
  - dest is tied to 0.
- stuck_high  out  1  sticky; timeout expired with the line high.
- stuck_low  out  1  sticky; timeout expired with the line low.
- overrun  out  1  sticky; a result was overwritten before it was accepted.

## Operation
- Synchronizer: two flops s1 and s2, plus a history flop s3. All three reset to 0.
  - rise = s2 & ~s3
  - fall = ~s2 & s3
- Counter cnt:
  - On rise, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at all-ones.
  - cnt resets to 0.
- State machine, reset state IDLE:
  - IDLE: wait for rise while enable=1, then go to HIGH. No result is produced for the first rise.
  - HIGH: on fall, latch high_time <= cnt and go to LOW.
  - LOW: on rise, latch period <= cnt, load the output register, and go to HIGH.
  - In any state other than IDLE, enable=0 sends the FSM to IDLE at the next edge. Any partial measurement is discarded.
  - Timeout: in HIGH or LOW with timeout_cycles≠0, if cnt == timeout_cycles and no edge occurs that cycle, then:
    - set stuck_high (state HIGH) or stuck_low (state LOW);
    - go to IDLE;
    - emit no beat.
- Output register: single entry holding data and valid.
  - The register is loaded on each completed period.
  - If valid=1 and ready=0 at load time, the data is overwritten and overrun is set.
  - valid clears on a valid&ready handshake unless a load happens in the same cycle. In that case valid stays 1, the new data is held, and overrun is not set.
- Sticky flags:
  - clear_status clears stuck_high, stuck_low and overrun.
  - If a flag is being set in the same cycle as clear_status, the set wins.
- Arithmetic: all counts are unsigned COUNTER_WIDTH. period ≥ high_time always holds, because both values come from the same counter run.
- Saturation: periods of 2^COUNTER_WIDTH cycles or more report all-ones in period. high_time saturates the same way.

## Timing
- Reset values:
  - data_out.valid=0 and data_out.data=0.
  - stuck_high, stuck_low and overrun are all 0.
  - FSM in IDLE.
- Input latency: a pwm_in transition first sampled high at clock edge k appears on s2 after edge k+1. rise is combinationally active in the following cycle, and the FSM acts on it at edge k+2.
- Result latency: data_out.valid rises at edge k+2 after the sampling edge k of the rising pwm_in transition that closes the period.
- Resolution:
  - Period and high time are exact in clock cycles for synchronous inputs.
  - With asynchronous inputs, each edge has ±1 cycle of sampling jitter.
- Minimum pulse: a high or low phase must last at least 2 cycles to be measured. Shorter pulses may be missed. Shorter pulses must not hang the FSM.
- Throughput: one beat per PWM period. Downstream must accept within one period to avoid overrun.
- A reset asserted mid-measurement returns every register to its reset value at the next edge.

## Test plan
- Square wave, period 10 clocks, high 4, ready=1.
  - The first rise emits nothing.
  - Every following period emits {high_time=4, period=10}.
  - valid is high for exactly 1 cycle per beat.
- Duty change: switch the wave from 4/10 to 7/10 cycles on the fly.
  - Exactly one transition beat {4 or 7, 10} appears.
  - After that, every beat is {7, 10}.
- Backpressure: hold ready=0 for 3 PWM periods, then assert it.
  - overrun=1.
  - The single beat delivered is the last period measured.
  - clear_status returns overrun to 0.
- Stuck line: timeout_cycles=50, pwm_in held high after a rise.
  - stuck_high=1 at 50 cycles after the rise is registered.
  - FSM is in IDLE and no beat is emitted.
  - After the line resumes toggling, beats return starting from the second rise.
- Reset during HIGH with valid=1 pending.
  - All outputs are 0 at the next edge.
  - Measurement restarts, and the first beat appears only after two fresh rises.
- enable deasserted mid-period, then reasserted.
  - No partial beat is emitted.
  - The next beat reports the correct full period.
